// File: rtl/mips_core_pkg.sv
// Shared fetch-path types: queue entry layout and thread-id width helper.
// Word widths default to 32 bits unless the surrounding build defines them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

   typedef struct packed {
      logic [`DATA_WIDTH-1:0] data;
      logic [`ADDR_WIDTH-1:0] pc;
   } fetch_entry_t;

   function automatic int tid_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int THREAD_ID_W = tid_width(2);

endpackage

// File: rtl/fetch_fifo.sv
// Single-thread instruction FIFO: head entry visible combinationally, push->head 1 cycle.
// Full is from the registered count only; flush clears the queue and discards same-cycle push/pop.
module fetch_fifo
   import mips_core_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_entry,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head_entry
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);
   assign do_push    = push & ~full & ~flush;
   assign do_pop     = pop & ~empty & ~flush;
   assign head_entry = mem[head];

   // Power-of-2 depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + 1'b1;
         if (do_pop)  head <= head + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[tail] <= push_entry;
   end

endmodule

// File: rtl/fetch_queue.sv
// Per-thread fetch queues with round-robin issue to decode; push->issue 1 cycle, full per thread.
// FETCH_QUEUE_BYPASS_EN adds a 0-cycle path when all queues are empty and decode is ready.
module fetch_queue
   import mips_core_pkg::*;
#(
   parameter int  NUM_THREADS = 2,
   parameter int  QUEUE_DEPTH = 4,
   localparam int TID_W       = tid_width(NUM_THREADS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_valid,
   input  logic [`DATA_WIDTH-1:0] i_data,
   input  logic [`ADDR_WIDTH-1:0] i_pc,
   input  logic [TID_W-1:0]       i_tid,
   input  logic [NUM_THREADS-1:0] i_flush,
   output logic [NUM_THREADS-1:0] o_full,
   output logic                   o_valid,
   output logic [`DATA_WIDTH-1:0] o_data,
   output logic [`ADDR_WIDTH-1:0] o_pc,
   output logic [TID_W-1:0]       o_tid,
   input  logic                   i_ready
);

   fetch_entry_t           head_entry [NUM_THREADS];
   fetch_entry_t           in_entry;
   fetch_entry_t           cur_entry;
   fetch_entry_t           last_entry;
   logic [NUM_THREADS-1:0] empty;
   logic [NUM_THREADS-1:0] push;
   logic [NUM_THREADS-1:0] pop;
   logic [TID_W-1:0]       rr;
   logic [TID_W-1:0]       sel;
   logic [TID_W-1:0]       cur_tid;
   logic [TID_W-1:0]       last_tid;
   logic                   any_valid;
   logic                   bypass;
   logic                   xfer;

   assign in_entry = '{data: i_data, pc: i_pc};

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = (&empty) & i_valid & ~i_flush[i_tid] & i_ready;
`else
   assign bypass = 1'b0;
`endif

   assign xfer = o_valid & i_ready;

   for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
      assign push[t] = i_valid & ~bypass & (i_tid == TID_W'(t));
      assign pop[t]  = xfer & ~bypass & (sel == TID_W'(t));

      fetch_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
         .clk        (clk),
         .rst_n      (rst_n),
         .push       (push[t]),
         .pop        (pop[t]),
         .flush      (i_flush[t]),
         .push_entry (in_entry),
         .full       (o_full[t]),
         .empty      (empty[t]),
         .head_entry (head_entry[t])
      );
   end

   // Scan downward so the non-empty thread nearest the rr pointer is the last to win.
   always_comb begin
      sel       = rr;
      any_valid = 1'b0;
      for (int k = NUM_THREADS - 1; k >= 0; k--) begin
         if (!empty[(int'(rr) + k) % NUM_THREADS]) begin
            sel       = TID_W'((int'(rr) + k) % NUM_THREADS);
            any_valid = 1'b1;
         end
      end
   end

   always_comb begin
      cur_entry = head_entry[sel];
      cur_tid   = sel;
      o_valid   = any_valid;
      if (bypass) begin
         cur_entry = in_entry;
         cur_tid   = i_tid;
         o_valid   = 1'b1;
      end
   end

   assign o_data = o_valid ? cur_entry.data : last_entry.data;
   assign o_pc   = o_valid ? cur_entry.pc   : last_entry.pc;
   assign o_tid  = o_valid ? cur_tid        : last_tid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr         <= '0;
         last_entry <= '0;
         last_tid   <= '0;
      end else begin
         if (xfer) rr <= TID_W'((int'(cur_tid) + 1) % NUM_THREADS);
         if (o_valid) begin
            last_entry <= cur_entry;
            last_tid   <= cur_tid;
         end
      end
   end

endmodule
